// File: rtl/sumador_branch_pkg.sv
// Shared datapath definitions for the LEGv8-style unicycle core.
// Holds the architectural width, the branch-offset scaling default
// and small helpers reused by the address-generation blocks.
package sumador_branch_pkg;

  localparam int XLEN                = 64;
  localparam int BRANCH_OFFSET_SHIFT = 2;

  typedef logic [XLEN-1:0] addr_t;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic signedAddOverflow(input logic aMsb,
                                             input logic bMsb,
                                             input logic sumMsb);
    return (aMsb == bMsb) && (sumMsb != aMsb);
  endfunction

  // Target addresses must be word aligned; any low bit set is flagged.
  function automatic logic wordMisaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/sumador_branch_core.sv
// Combinational branch-target generator: scales the word offset to
// bytes, adds it to the PC modulo 2^XLEN and derives the status flags.
module branch_adder_core
  import sumador_branch_pkg::*;
#(
  parameter int XLEN         = sumador_branch_pkg::XLEN,
  parameter int OFFSET_SHIFT = BRANCH_OFFSET_SHIFT
) (
  input  logic [XLEN-1:0] inputPC,
  input  logic [XLEN-1:0] inputSEU,
  output logic [XLEN-1:0] target,
  output logic            overflow,
  output logic            misaligned
);

  logic signed [XLEN-1:0] offScaled;
  logic signed [XLEN-1:0] pcSigned;
  logic signed [XLEN-1:0] sumSigned;

  // Shift, add and flag generation; bits shifted out and carry-out are dropped.
  always_comb begin
    pcSigned   = $signed(inputPC);
    offScaled  = $signed(inputSEU) <<< OFFSET_SHIFT;
    sumSigned  = pcSigned + offScaled;
    target     = sumSigned;
    overflow   = signedAddOverflow(pcSigned[XLEN-1], offScaled[XLEN-1],
                                   sumSigned[XLEN-1]);
    misaligned = wordMisaligned(sumSigned[1:0]);
  end

endmodule

// File: rtl/sumador_branch.sv
// Branch-target adder: registers the PC + scaled offset result for the
// PC-source mux, with a valid flag and overflow/misalignment status.
// One-cycle latency, full throughput, no backpressure.
module sumador_branch
  import sumador_branch_pkg::*;
#(
  parameter int XLEN         = sumador_branch_pkg::XLEN,
  parameter int OFFSET_SHIFT = BRANCH_OFFSET_SHIFT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] inputPC,
  input  logic [XLEN-1:0] inputSEU,
  output logic [XLEN-1:0] Nextinst,
  output logic            out_valid,
  output logic            overflow,
  output logic            misaligned
);

  logic [XLEN-1:0] target_p0;
  logic            ovf_p0;
  logic            mis_p0;

  logic [XLEN-1:0] target_p1;
  logic            ovf_p1;
  logic            mis_p1;
  logic            vld_p1;

  branch_adder_core #(
    .XLEN         (XLEN),
    .OFFSET_SHIFT (OFFSET_SHIFT)
  ) uCore (
    .inputPC    (inputPC),
    .inputSEU   (inputSEU),
    .target     (target_p0),
    .overflow   (ovf_p0),
    .misaligned (mis_p0)
  );

  // p0 -> p1: valid tracks in_valid every cycle; result loads only on valid input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      target_p1 <= '0;
      ovf_p1    <= 1'b0;
      mis_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        target_p1 <= target_p0;
        ovf_p1    <= ovf_p0;
        mis_p1    <= mis_p0;
      end
    end
  end

  assign Nextinst   = target_p1;
  assign out_valid  = vld_p1;
  assign overflow   = ovf_p1;
  assign misaligned = mis_p1;

endmodule

// File: tb/tb_sumador_branch.sv
// Self-checking bench for sumador_branch: directed vectors plus random
// traffic against an arithmetic reference model of the branch target.
module tb_sumador_branch;

  localparam int XLEN  = 64;
  localparam int SHIFT = 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [XLEN-1:0] inputPC;
  logic [XLEN-1:0] inputSEU;
  logic [XLEN-1:0] Nextinst;
  logic            out_valid;
  logic            overflow;
  logic            misaligned;

  int checks;
  int failures;

  // Reference state: what the registered outputs should hold.
  logic [XLEN-1:0] expTarget;
  logic            expValid;
  logic            expOvf;
  logic            expMis;

  sumador_branch #(
    .XLEN         (XLEN),
    .OFFSET_SHIFT (SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .inputPC    (inputPC),
    .inputSEU   (inputSEU),
    .Nextinst   (Nextinst),
    .out_valid  (out_valid),
    .overflow   (overflow),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [XLEN-1:0] got,
                          input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".Nextinst"},   Nextinst,          expTarget);
    checkVal({tag, ".out_valid"},  {63'd0, out_valid}, {63'd0, expValid});
    checkVal({tag, ".overflow"},   {63'd0, overflow},  {63'd0, expOvf});
    checkVal({tag, ".misaligned"}, {63'd0, misaligned}, {63'd0, expMis});
  endtask

  // Model: byte offset = word offset * 2^SHIFT, target taken modulo 2^64,
  // overflow decided by whether the exact signed sum leaves the 64-bit range.
  task automatic modelApply(input logic v, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] seu);
    logic [XLEN-1:0]   off;
    logic signed [XLEN+1:0] exact;
    logic signed [XLEN+1:0] maxS;
    logic signed [XLEN+1:0] minS;
    expValid = v;
    if (v) begin
      off   = seu * (64'd1 << SHIFT);
      expTarget = pc + off;
      exact = $signed({{2{pc[XLEN-1]}}, pc}) + $signed({{2{off[XLEN-1]}}, off});
      maxS  = (66'sd1 <<< (XLEN-1)) - 66'sd1;
      minS  = -(66'sd1 <<< (XLEN-1));
      expOvf = (exact > maxS) || (exact < minS);
      expMis = (expTarget % 4) != 0;
    end
  endtask

  task automatic drive(input string tag, input logic v,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] seu);
    in_valid = v;
    inputPC  = pc;
    inputSEU = seu;
    @(posedge clk);
    #1;
    modelApply(v, pc, seu);
    checkAll(tag);
  endtask

  initial begin
    logic [XLEN-1:0] heldTarget;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    inputPC  = '0;
    inputSEU = '0;
    expTarget = '0;
    expValid  = 1'b0;
    expOvf    = 1'b0;
    expMis    = 1'b0;

    // Reset held across several clock edges.
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    drive("negpc_posoff", 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 64'd5);
    checkVal("negpc_posoff.literal", Nextinst, 64'h0000_0000_0000_0005);
    drive("backward", 1'b1, 64'h0000_0000_0000_1000, 64'hFFFF_FFFF_FFFF_FFFF);
    checkVal("backward.literal", Nextinst, 64'h0000_0000_0000_0FFC);
    drive("sovf", 1'b1, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1);
    checkVal("sovf.literal", Nextinst, 64'h8000_0000_0000_0000);
    checkVal("sovf.flag", {63'd0, overflow}, 64'd1);
    drive("uwrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1);
    checkVal("uwrap.literal", Nextinst, 64'd0);
    // Negative overflow and shifted-out offset bits.
    drive("negovf", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    drive("shiftout", 1'b1, 64'h0000_0000_0000_0010, 64'h4000_0000_0000_0001);

    // Random traffic with random valid gaps.
    for (int i = 0; i < 300; i++) begin
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] seu;
      pc  = {$urandom, $urandom};
      seu = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) seu = {{40{seu[23]}}, seu[23:0]};
      drive("random", ($urandom_range(0, 3) != 0), pc, seu);
    end

    // Hold: dropping valid clears out_valid and keeps the last result.
    drive("loadForHold", 1'b1, 64'h0000_0000_0040_0000, 64'd7);
    heldTarget = Nextinst;
    drive("hold", 1'b0, 64'hDEAD_BEEF_0000_0003, 64'h1234);
    checkVal("hold.literal", Nextinst, 64'h0000_0000_0040_001C);
    checkVal("hold.same", Nextinst, heldTarget);

    // Async reset between edges clears outputs without a clock edge.
    drive("preReset", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expTarget = '0;
    expValid  = 1'b0;
    expOvf    = 1'b0;
    expMis    = 1'b0;
    checkAll("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;
    drive("postReset", 1'b1, 64'h0000_0000_0000_2000, 64'd3);
    checkVal("postReset.literal", Nextinst, 64'h0000_0000_0000_200C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
